// File: rtl/ace_line_engine_if.sv
// Bundle of the line-request, datapath and ACE channel signals of ace_line_engine.
// The engine is the ACE master; the slave modport is the environment's view.
interface ace_line_engine_if #(
  parameter int WIDTH_A    = 32,
  parameter int WIDTH_D    = 32,
  parameter int LINE_WORDS = 4
);
  localparam int IDX = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  // Line request and completion
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic               req_unique;
  logic [WIDTH_A-1:0] req_addr;
  logic               done;
  logic               err;

  // Datapath word ports
  logic [IDX-1:0]     wb_index;
  logic [WIDTH_D-1:0] wb_data;
  logic               fill_we;
  logic [IDX-1:0]     fill_index;
  logic [WIDTH_D-1:0] fill_data;

  // ACE read channels
  logic               AR_VALID;
  logic               AR_READY;
  logic [WIDTH_A-1:0] AR_ADDR;
  logic [7:0]         AR_LEN;
  logic [2:0]         AR_SIZE;
  logic [1:0]         AR_BURST;
  logic [3:0]         AR_SNOOP;
  logic               R_VALID;
  logic               R_READY;
  logic [WIDTH_D-1:0] RDATA;
  logic [3:0]         RRESP;
  logic               R_LAST;

  // ACE write channels
  logic               AW_VALID;
  logic               AW_READY;
  logic [WIDTH_A-1:0] AW_ADDR;
  logic [7:0]         AW_LEN;
  logic [2:0]         AW_SIZE;
  logic [1:0]         AW_BURST;
  logic [2:0]         AW_SNOOP;
  logic               W_VALID;
  logic               W_READY;
  logic [WIDTH_D-1:0] W_DATA;
  logic               W_LAST;
  logic               B_VALID;
  logic               B_READY;
  logic [1:0]         BRESP;

  modport master (
    input  req_valid, req_write, req_unique, req_addr, wb_data,
           AR_READY, R_VALID, RDATA, RRESP, R_LAST,
           AW_READY, W_READY, B_VALID, BRESP,
    output req_ready, done, err, wb_index, fill_we, fill_index, fill_data,
           AR_VALID, AR_ADDR, AR_LEN, AR_SIZE, AR_BURST, AR_SNOOP, R_READY,
           AW_VALID, AW_ADDR, AW_LEN, AW_SIZE, AW_BURST, AW_SNOOP,
           W_VALID, W_DATA, W_LAST, B_READY
  );

  modport slave (
    output req_valid, req_write, req_unique, req_addr, wb_data,
           AR_READY, R_VALID, RDATA, RRESP, R_LAST,
           AW_READY, W_READY, B_VALID, BRESP,
    input  req_ready, done, err, wb_index, fill_we, fill_index, fill_data,
           AR_VALID, AR_ADDR, AR_LEN, AR_SIZE, AR_BURST, AR_SNOOP, R_READY,
           AW_VALID, AW_ADDR, AW_LEN, AW_SIZE, AW_BURST, AW_SNOOP,
           W_VALID, W_DATA, W_LAST, B_READY
  );
endinterface

// File: rtl/ace_line_engine.sv
// Single-outstanding ACE line engine: fills a cache line with ReadShared/ReadUnique
// or writes one back with WriteBack, reporting completion with a done/err pulse.
module ace_line_engine #(
  parameter int WIDTH_A    = 32,
  parameter int WIDTH_D    = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  ace_line_engine_if.master  bus
);

  localparam int                 IDX       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int                 OFF       = $clog2(LINE_WORDS * WIDTH_D / 8);
  localparam logic [IDX-1:0]     LAST_IDX  = IDX'(LINE_WORDS - 1);
  localparam logic [WIDTH_A-1:0] ADDR_MASK = ~((WIDTH_A'(1) << OFF) - WIDTH_A'(1));
  localparam logic [7:0]         BURST_LEN = 8'(LINE_WORDS - 1);
  localparam logic [2:0]         BEAT_SIZE = 3'($clog2(WIDTH_D / 8));

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_e;

  state_e             r_state;
  logic [IDX-1:0]     r_cnt;
  logic               r_over;
  logic               r_err;
  logic               r_err_out;
  logic               r_done;
  logic               r_req_ready;
  logic               r_ar_valid;
  logic               r_r_ready;
  logic               r_aw_valid;
  logic               r_w_valid;
  logic               r_b_ready;
  logic [WIDTH_A-1:0] r_addr;
  logic               r_unique;

  logic w_accept;
  logic w_r_beat;
  logic w_r_bad;
  logic w_w_hs;
  logic w_at_last;
  logic w_unused_rresp;

  assign w_accept  = bus.req_valid & r_req_ready;
  assign w_r_beat  = r_r_ready & bus.R_VALID;
  assign w_w_hs    = r_w_valid & bus.W_READY;
  assign w_at_last = (r_cnt == LAST_IDX);

  // A beat is bad on a slave error, when it lies past the line, or when the burst ends early.
  assign w_r_bad = (bus.RRESP[1:0] != 2'b00) | r_over | (bus.R_LAST & ~w_at_last);

  // IsShared/PassDirty carry coherence state that this engine does not track.
  assign w_unused_rresp = ^bus.RRESP[3:2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_over      <= 1'b0;
      r_err       <= 1'b0;
      r_err_out   <= 1'b0;
      r_done      <= 1'b0;
      r_req_ready <= 1'b0;
      r_ar_valid  <= 1'b0;
      r_r_ready   <= 1'b0;
      r_aw_valid  <= 1'b0;
      r_w_valid   <= 1'b0;
      r_b_ready   <= 1'b0;
      r_addr      <= '0;
      r_unique    <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the same cycle overrides them.
      r_done    <= 1'b0;
      r_err_out <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_req_ready <= ~w_accept;
          if (w_accept) begin
            r_addr   <= bus.req_addr & ADDR_MASK;
            r_unique <= bus.req_unique;
            r_cnt    <= '0;
            r_over   <= 1'b0;
            r_err    <= 1'b0;
            if (bus.req_write) begin
              r_aw_valid <= 1'b1;
              r_state    <= S_AW;
            end else begin
              r_ar_valid <= 1'b1;
              r_state    <= S_AR;
            end
          end
        end

        S_AR: begin
          if (bus.AR_READY) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= S_R;
          end
        end

        S_R: begin
          if (w_r_beat) begin
            // The counter saturates on the last word; later beats only raise the overflow flag.
            if (!w_at_last) begin
              r_cnt <= r_cnt + 1'b1;
            end else if (!bus.R_LAST) begin
              r_over <= 1'b1;
            end
            if (bus.R_LAST) begin
              r_r_ready <= 1'b0;
              r_done    <= 1'b1;
              r_err_out <= r_err | w_r_bad;
              r_state   <= S_DONE;
            end else begin
              r_err <= r_err | w_r_bad;
            end
          end
        end

        S_AW: begin
          if (bus.AW_READY) begin
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b1;
            r_state    <= S_W;
          end
        end

        S_W: begin
          if (w_w_hs) begin
            if (w_at_last) begin
              r_w_valid <= 1'b0;
              r_b_ready <= 1'b1;
              r_state   <= S_B;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_B: begin
          if (bus.B_VALID) begin
            r_b_ready <= 1'b0;
            r_done    <= 1'b1;
            r_err_out <= r_err | (bus.BRESP != 2'b00);
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.done      = r_done;
  assign bus.err       = r_err_out;

  assign bus.AR_VALID = r_ar_valid;
  assign bus.AR_ADDR  = r_addr;
  assign bus.AR_LEN   = BURST_LEN;
  assign bus.AR_SIZE  = BEAT_SIZE;
  assign bus.AR_BURST = 2'b01;
  assign bus.AR_SNOOP = r_unique ? 4'b0111 : 4'b0001;
  assign bus.R_READY  = r_r_ready;

  // The write port is gated by reset so a beat landing in the reset cycle never reaches the line.
  assign bus.fill_we    = rst_n & w_r_beat & ~r_over;
  assign bus.fill_index = r_cnt;
  assign bus.fill_data  = bus.RDATA;

  assign bus.AW_VALID = r_aw_valid;
  assign bus.AW_ADDR  = r_addr;
  assign bus.AW_LEN   = BURST_LEN;
  assign bus.AW_SIZE  = BEAT_SIZE;
  assign bus.AW_BURST = 2'b01;
  assign bus.AW_SNOOP = 3'b011;
  assign bus.W_VALID  = r_w_valid;
  assign bus.W_DATA   = bus.wb_data;
  assign bus.W_LAST   = r_w_valid & w_at_last;
  assign bus.wb_index = r_cnt;
  assign bus.B_READY  = r_b_ready;

endmodule

// File: tb/tb_ace_line_engine.sv
// Scoreboard bench for ace_line_engine: stimulus pushes expected AR/AW, fill, W and
// completion records; a negedge monitor pops and compares whatever the DUT presents.
module tb_ace_line_engine;

  localparam int WA = 32;
  localparam int WD = 32;
  localparam int LW = 4;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  snoop;
  } addr_t;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
  } fill_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } wbeat_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail = 0;
  int   sweep_cnt = 0;

  addr_t  q_ar[$];
  addr_t  q_aw[$];
  fill_t  q_fill[$];
  wbeat_t q_w[$];
  bit     q_done[$];

  always #5 clk = ~clk;

  ace_line_engine_if #(.WIDTH_A(WA), .WIDTH_D(WD), .LINE_WORDS(LW)) u_if ();

  ace_line_engine #(.WIDTH_A(WA), .WIDTH_D(WD), .LINE_WORDS(LW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.master)
  );

  // Datapath model: the line word at index k reads as 0xC0DE0000 + k.
  assign u_if.wb_data = 32'hC0DE_0000 | 32'(u_if.wb_index);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mark_sweep();
    sweep_cnt++;
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    bit     prev_done = 1'b0;
    addr_t  a;
    fill_t  f;
    wbeat_t w;
    bit     e;
    forever begin
      @(negedge clk);
      if (u_if.AR_VALID) begin
        check("ar_pending", 64'(q_ar.size() > 0), 64'd1);
        if (q_ar.size() > 0) begin
          a = q_ar[0];
          check("ar_addr",  64'(u_if.AR_ADDR),  64'(a.addr));
          check("ar_len",   64'(u_if.AR_LEN),   64'(a.len));
          check("ar_size",  64'(u_if.AR_SIZE),  64'(a.size));
          check("ar_burst", 64'(u_if.AR_BURST), 64'(a.burst));
          check("ar_snoop", 64'(u_if.AR_SNOOP), 64'(a.snoop));
          if (u_if.AR_READY) void'(q_ar.pop_front());
        end
      end
      if (u_if.AW_VALID) begin
        check("aw_pending", 64'(q_aw.size() > 0), 64'd1);
        if (q_aw.size() > 0) begin
          a = q_aw[0];
          check("aw_addr",  64'(u_if.AW_ADDR),  64'(a.addr));
          check("aw_len",   64'(u_if.AW_LEN),   64'(a.len));
          check("aw_size",  64'(u_if.AW_SIZE),  64'(a.size));
          check("aw_burst", 64'(u_if.AW_BURST), 64'(a.burst));
          check("aw_snoop", 64'(u_if.AW_SNOOP), 64'(a.snoop));
          if (u_if.AW_READY) void'(q_aw.pop_front());
        end
      end
      if (u_if.fill_we) begin
        check("fill_pending", 64'(q_fill.size() > 0), 64'd1);
        if (q_fill.size() > 0) begin
          f = q_fill.pop_front();
          check("fill_index", 64'(u_if.fill_index), 64'(f.idx));
          check("fill_data",  64'(u_if.fill_data),  64'(f.data));
        end
      end
      if (u_if.W_VALID && u_if.W_READY) begin
        check("w_pending", 64'(q_w.size() > 0), 64'd1);
        if (q_w.size() > 0) begin
          w = q_w.pop_front();
          check("w_data", 64'(u_if.W_DATA), 64'(w.data));
          check("w_last", 64'(u_if.W_LAST), 64'(w.last));
        end
      end
      if (prev_done) check("done_one_cycle", 64'(u_if.done), 64'd0);
      if (u_if.done) begin
        check("done_pending", 64'(q_done.size() > 0), 64'd1);
        if (q_done.size() > 0) begin
          e = q_done.pop_front();
          check("done_err", 64'(u_if.err), 64'(e));
        end
      end else begin
        check("err_outside_done", 64'(u_if.err), 64'd0);
      end
      prev_done = u_if.done;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic issue_req(input logic [31:0] addr, input bit wr, input bit uniq);
    int cyc = 0;
    u_if.req_addr   = addr;
    u_if.req_write  = wr;
    u_if.req_unique = uniq;
    u_if.req_valid  = 1'b1;
    while (!u_if.req_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("req_ready_wait", 64'(cyc < 50), 64'd1);
    @(posedge clk); #1;
    u_if.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!u_if.done && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_wait", 64'(cyc < 50), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [31:0] data, input int k, input bit last,
                           input logic [3:0] resp, input bit expect_fill);
    fill_t f;
    if (expect_fill) begin
      f.idx  = 2'(k);
      f.data = data;
      q_fill.push_back(f);
    end
    u_if.R_VALID = 1'b1;
    u_if.RDATA   = data;
    u_if.RRESP   = resp;
    u_if.R_LAST  = last;
    @(posedge clk); #1;
    u_if.R_VALID = 1'b0;
    u_if.R_LAST  = 1'b0;
    u_if.RRESP   = 4'b0000;
  endtask

  task automatic start_fill(input logic [31:0] addr, input bit uniq, input int ar_delay);
    addr_t a;
    int    cyc = 0;
    a.addr  = addr & 32'hFFFF_FFF0;
    a.len   = 8'd3;
    a.size  = 3'd2;
    a.burst = 2'b01;
    a.snoop = uniq ? 4'b0111 : 4'b0001;
    q_ar.push_back(a);
    issue_req(addr, 1'b0, uniq);
    while (!u_if.AR_VALID && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ar_valid_wait", 64'(cyc < 50), 64'd1);
    repeat (ar_delay) begin
      @(posedge clk); #1;
    end
    u_if.AR_READY = 1'b1;
    @(posedge clk); #1;
    u_if.AR_READY = 1'b0;
  endtask

  // nbeats beats with R_LAST on the final one; bad_beat >= 0 carries SLVERR.
  task automatic do_fill(input logic [31:0] addr, input bit uniq, input int ar_delay,
                         input int nbeats, input int bad_beat, input logic [31:0] base,
                         input logic [3:0] ok_resp);
    q_done.push_back((nbeats != LW) || (bad_beat >= 0));
    start_fill(addr, uniq, ar_delay);
    for (int k = 0; k < nbeats; k++) begin
      send_beat(base + 32'(k), k, k == nbeats - 1,
                (k == bad_beat) ? 4'b0010 : ok_resp, k < LW);
    end
    wait_done();
  endtask

  task automatic do_wb(input logic [31:0] addr, input int aw_delay, input logic [1:0] bresp);
    addr_t  a;
    wbeat_t w;
    int     cyc = 0;
    int     hs = 0;
    a.addr  = addr & 32'hFFFF_FFF0;
    a.len   = 8'd3;
    a.size  = 3'd2;
    a.burst = 2'b01;
    a.snoop = 4'b0011;
    q_aw.push_back(a);
    for (int k = 0; k < LW; k++) begin
      w.data = 32'hC0DE_0000 + 32'(k);
      w.last = (k == LW - 1);
      q_w.push_back(w);
    end
    q_done.push_back(bresp != 2'b00);
    issue_req(addr, 1'b1, 1'b0);
    while (!u_if.AW_VALID && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("aw_valid_wait", 64'(cyc < 50), 64'd1);
    repeat (aw_delay) begin
      @(posedge clk); #1;
    end
    u_if.AW_READY = 1'b1;
    @(posedge clk); #1;
    u_if.AW_READY = 1'b0;
    cyc = 0;
    while (hs < LW && cyc < 100) begin
      u_if.W_READY = (cyc % 2 == 1);
      if (u_if.W_VALID && u_if.W_READY) hs++;
      @(posedge clk); #1;
      cyc++;
    end
    u_if.W_READY = 1'b0;
    check("w_beats", 64'(hs), 64'(LW));
    u_if.B_VALID = 1'b1;
    u_if.BRESP   = bresp;
    cyc = 0;
    while (!u_if.B_READY && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b_ready_wait", 64'(cyc < 50), 64'd1);
    @(posedge clk); #1;
    u_if.B_VALID = 1'b0;
    u_if.BRESP   = 2'b00;
    wait_done();
  endtask

  // ---------------------------------------------------------------- main sequence
  initial begin
    int cyc;
    rst_n           = 1'b0;
    u_if.req_valid  = 1'b0;
    u_if.req_write  = 1'b0;
    u_if.req_unique = 1'b0;
    u_if.req_addr   = '0;
    u_if.AR_READY   = 1'b0;
    u_if.R_VALID    = 1'b0;
    u_if.RDATA      = '0;
    u_if.RRESP      = 4'b0000;
    u_if.R_LAST     = 1'b0;
    u_if.AW_READY   = 1'b0;
    u_if.W_READY    = 1'b0;
    u_if.B_VALID    = 1'b0;
    u_if.BRESP      = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ar_valid",  64'(u_if.AR_VALID),  64'd0);
    check("rst_aw_valid",  64'(u_if.AW_VALID),  64'd0);
    check("rst_w_valid",   64'(u_if.W_VALID),   64'd0);
    check("rst_r_ready",   64'(u_if.R_READY),   64'd0);
    check("rst_b_ready",   64'(u_if.B_READY),   64'd0);
    check("rst_req_ready", 64'(u_if.req_ready), 64'd0);
    check("rst_done",      64'(u_if.done),      64'd0);
    check("rst_fill_we",   64'(u_if.fill_we),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("req_ready_after_reset", 64'(u_if.req_ready), 64'd1);

    // Plain ReadShared fill of 0x1234 -> line 0x1230, words 0xA..0xD.
    do_fill(32'h0000_1234, 1'b0, 0, 4, -1, 32'h0000_000A, 4'b0000);
    // Writeback with AW_READY held off three cycles and W_READY toggling.
    do_wb(32'h8000_0ABC, 3, 2'b00);
    // Burst ends on the second beat of four.
    do_fill(32'h0000_0040, 1'b0, 1, 2, -1, 32'h1111_0000, 4'b0000);
    // Writeback answered with SLVERR, then a ReadUnique fill from IDLE.
    do_wb(32'h0000_0100, 0, 2'b10);
    do_fill(32'h0000_2008, 1'b1, 2, 4, -1, 32'h2222_0000, 4'b0000);
    // Two beats past the line before R_LAST.
    do_fill(32'h0000_3000, 1'b0, 0, 6, -1, 32'h3333_0000, 4'b0000);
    // SLVERR on beat 1 of a ReadUnique fill.
    do_fill(32'h0000_4004, 1'b1, 0, 4, 1, 32'h4444_0000, 4'b0000);

    // Reset lands on beat 2 of a fill: no done, no write for that beat.
    start_fill(32'h0000_5000, 1'b0, 0);
    send_beat(32'h5555_0000, 0, 1'b0, 4'b0000, 1'b1);
    send_beat(32'h5555_0001, 1, 1'b0, 4'b0000, 1'b1);
    u_if.R_VALID = 1'b1;
    u_if.RDATA   = 32'h5555_0002;
    rst_n        = 1'b0;
    @(posedge clk); #1;
    u_if.R_VALID = 1'b0;
    check("reset_r_ready", 64'(u_if.R_READY), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("req_ready_after_abort", 64'(u_if.req_ready), 64'd1);
    // Normal fill afterwards; IsShared/PassDirty bits alone are not an error.
    do_fill(32'h0000_6000, 1'b0, 0, 4, -1, 32'h6666_0000, 4'b1100);

    cyc = 0;
    while (sweep_cnt < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("sweep_complete", 64'(sweep_cnt), 64'd3);
    repeat (3) @(posedge clk);
    #1;
    check("q_ar_empty",   64'(q_ar.size()),   64'd0);
    check("q_aw_empty",   64'(q_aw.size()),   64'd0);
    check("q_fill_empty", 64'(q_fill.size()), 64'd0);
    check("q_w_empty",    64'(q_w.size()),    64'd0);
    check("q_done_empty", 64'(q_done.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------- geometry sweep
  // 64-bit beats with 1, 8 and 16 words per line: lines of 8, 64 and 128 bytes.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int          SW_LW   = (g == 0) ? 1 : ((g == 1) ? 8 : 16);
    localparam logic [31:0] SW_ADDR = (g == 0) ? 32'hFFFF_FFF8 :
                                      ((g == 1) ? 32'hFFFF_FFC0 : 32'hFFFF_FF80);
    logic s_rst_n;

    ace_line_engine_if #(.WIDTH_A(32), .WIDTH_D(64), .LINE_WORDS(SW_LW)) s_if ();

    ace_line_engine #(.WIDTH_A(32), .WIDTH_D(64), .LINE_WORDS(SW_LW)) u_sw (
      .clk   (clk),
      .rst_n (s_rst_n),
      .bus   (s_if.master)
    );

    assign s_if.wb_data = '0;

    initial begin
      int          cyc;
      logic [63:0] d;
      s_rst_n         = 1'b0;
      s_if.req_valid  = 1'b0;
      s_if.req_write  = 1'b0;
      s_if.req_unique = 1'b0;
      s_if.req_addr   = '0;
      s_if.AR_READY   = 1'b0;
      s_if.R_VALID    = 1'b0;
      s_if.RDATA      = '0;
      s_if.RRESP      = 4'b0000;
      s_if.R_LAST     = 1'b0;
      s_if.AW_READY   = 1'b0;
      s_if.W_READY    = 1'b0;
      s_if.B_VALID    = 1'b0;
      s_if.BRESP      = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      s_rst_n = 1'b1;
      @(posedge clk); #1;
      check("sw_req_ready", 64'(s_if.req_ready), 64'd1);
      s_if.req_addr  = 32'hFFFF_FFFF;
      s_if.req_valid = 1'b1;
      @(posedge clk); #1;
      s_if.req_valid = 1'b0;
      cyc = 0;
      while (!s_if.AR_VALID && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("sw_ar_valid_wait", 64'(cyc < 20), 64'd1);
      check("sw_ar_addr",  64'(s_if.AR_ADDR),  64'(SW_ADDR));
      check("sw_ar_len",   64'(s_if.AR_LEN),   64'(SW_LW - 1));
      check("sw_ar_size",  64'(s_if.AR_SIZE),  64'd3);
      check("sw_ar_burst", 64'(s_if.AR_BURST), 64'd1);
      s_if.AR_READY = 1'b1;
      @(posedge clk); #1;
      s_if.AR_READY = 1'b0;
      for (int k = 0; k < SW_LW; k++) begin
        d = {32'h5EED_0000 | 32'(g), 32'(k)};
        s_if.R_VALID = 1'b1;
        s_if.RDATA   = d;
        s_if.R_LAST  = (k == SW_LW - 1);
        @(negedge clk);
        check("sw_fill_we",    64'(s_if.fill_we),    64'd1);
        check("sw_fill_index", 64'(s_if.fill_index), 64'(k));
        check("sw_fill_data",  64'(s_if.fill_data),  d);
        @(posedge clk); #1;
      end
      s_if.R_VALID = 1'b0;
      s_if.R_LAST  = 1'b0;
      check("sw_done", 64'(s_if.done), 64'd1);
      check("sw_err",  64'(s_if.err),  64'd0);
      mark_sweep();
    end
  end

endmodule
